// File: rtl/frac_reduce.sv
// Reduces a fraction num/den by a supplied gcd with one shared restoring divider, numerator first.
// Latency: out_valid rises 2*WIDTH+1 edges after the accepting edge, counting that edge; a zero gcd takes 1 edge.
// Backpressure: in_ready only in IDLE; results held in OUT until out_ready. FRAC_REDUCE_REM_CHECK_EN adds a remainder check.
module frac_reduce #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num_in,
    input  logic [WIDTH-1:0] den_in,
    input  logic [WIDTH-1:0] gcd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] num_out,
    output logic [WIDTH-1:0] den_out,
    output logic             div_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_NUM = 2'd1,
        DIV_DEN = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;

    // dvd shifts left each step; quotient bits fill in from the LSB end,
    // so after WIDTH steps it holds the quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] den_r;
    logic [WIDTH-1:0] g_r;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
`ifdef FRAC_REDUCE_REM_CHECK_EN
    logic             num_rem_nz;
`endif

    logic             last;
    logic [WIDTH:0]   rem_sh;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] dvd_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign last      = (cnt == CW'(WIDTH - 1));

    // One restoring step: partial remainder is WIDTH+1 bits before the compare,
    // and always fits WIDTH bits afterwards because it ends below g.
    always_comb begin
        rem_sh = {rem, dvd[WIDTH-1]};
        q_bit  = (rem_sh >= {1'b0, g_r});
        rem_nx = q_bit ? WIDTH'(rem_sh - {1'b0, g_r}) : rem_sh[WIDTH-1:0];
        dvd_nx = {dvd[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = (gcd_in == '0) ? OUT : DIV_NUM;
                end
            end
            DIV_NUM: begin
                if (last) begin
                    state_nx = DIV_DEN;
                end
            end
            DIV_DEN: begin
                if (last) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd     <= '0;
            den_r   <= '0;
            g_r     <= '0;
            rem     <= '0;
            cnt     <= '0;
            num_out <= '0;
            den_out <= '0;
            div_err <= 1'b0;
`ifdef FRAC_REDUCE_REM_CHECK_EN
            num_rem_nz <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd   <= num_in;
                        den_r <= den_in;
                        g_r   <= gcd_in;
                        rem   <= '0;
                        cnt   <= '0;
                        if (gcd_in == '0) begin
                            num_out <= '0;
                            den_out <= '0;
                            div_err <= 1'b1;
                        end
                    end
                end
                DIV_NUM: begin
                    if (last) begin
                        num_out <= dvd_nx;
                        dvd     <= den_r;
                        rem     <= '0;
                        cnt     <= '0;
`ifdef FRAC_REDUCE_REM_CHECK_EN
                        num_rem_nz <= (rem_nx != '0);
`endif
                    end else begin
                        dvd <= dvd_nx;
                        rem <= rem_nx;
                        cnt <= cnt + CW'(1);
                    end
                end
                DIV_DEN: begin
                    if (last) begin
                        den_out <= dvd_nx;
                        dvd     <= '0;
                        rem     <= '0;
                        cnt     <= '0;
`ifdef FRAC_REDUCE_REM_CHECK_EN
                        div_err    <= num_rem_nz | (rem_nx != '0);
                        num_rem_nz <= 1'b0;
`else
                        div_err <= 1'b0;
`endif
                    end else begin
                        dvd <= dvd_nx;
                        rem <= rem_nx;
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frac_reduce.sv
// Directed bench for frac_reduce: arithmetic reference model checked every output-valid cycle,
// plus hand-computed literal expectations for latency, values, backpressure and reset.
module tb_frac_reduce;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] num_in;
    logic [7:0] den_in;
    logic [7:0] gcd_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] num_out;
    logic [7:0] den_out;
    logic       div_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] n;
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t exp_q[$];

    frac_reduce #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_in    (num_in),
        .den_in    (den_in),
        .gcd_in    (gcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .num_out   (num_out),
        .den_out   (den_out),
        .div_err   (div_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, want);
        end
    endtask

    // Reference: plain integer division, error on zero gcd (or inexact division when checked).
    function automatic exp_t model(input logic [7:0] n, input logic [7:0] d, input logic [7:0] g);
        exp_t r;
        if (g == 8'd0) begin
            r.n = 8'd0;
            r.d = 8'd0;
            r.e = 1'b1;
        end else begin
            r.n = n / g;
            r.d = d / g;
`ifdef FRAC_REDUCE_REM_CHECK_EN
            r.e = ((n % g) != 0) || ((d % g) != 0);
`else
            r.e = 1'b0;
`endif
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL model_spurious_out_valid actual=1 expected=0");
            end else begin
                chk("model_num_out", num_out, exp_q[0].n);
                chk("model_den_out", den_out, exp_q[0].d);
                chk("model_div_err", div_err, exp_q[0].e);
                chk("model_in_ready_in_out", in_ready, 0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Offers one triple, checks latency and literal results; completes the handshake if out_ready is high.
    task automatic run(input string nm, input logic [7:0] n, input logic [7:0] d, input logic [7:0] g,
                       input logic [7:0] en, input logic [7:0] ed, input logic ee, input int elat);
        int lat;
        chk({nm, "_in_ready"}, in_ready, 1);
        num_in   = n;
        den_in   = d;
        gcd_in   = g;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(n, d, g));
        // Junk on the inputs afterwards; while dividing, in_valid is held high too and must be ignored.
        num_in   = ~n;
        den_in   = 8'h5A;
        gcd_in   = ~g;
        in_valid = (g != 8'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat >= 4) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_num_out"}, num_out, en);
        chk({nm, "_den_out"}, den_out, ed);
        chk({nm, "_div_err"}, div_err, ee);
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk({nm, "_valid_drop"}, out_valid, 0);
            chk({nm, "_ready_back"}, in_ready, 1);
            chk({nm, "_num_kept"}, num_out, en);
            chk({nm, "_den_kept"}, den_out, ed);
        end
    endtask

    logic exp_rem_err;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        num_in    = 8'd0;
        den_in    = 8'd0;
        gcd_in    = 8'd0;
        out_ready = 1'b1;
`ifdef FRAC_REDUCE_REM_CHECK_EN
        exp_rem_err = 1'b1;
`else
        exp_rem_err = 1'b0;
`endif
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_num_out", num_out, 0);
        chk("rst_den_out", den_out, 0);
        chk("rst_div_err", div_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("basic",   8'd12,  8'd18,  8'd6,   8'd2, 8'd3, 1'b0, 17);
        run("zero_num", 8'd0,  8'd5,   8'd5,   8'd0, 8'd1, 1'b0, 17);
        run("max",     8'd255, 8'd255, 8'd255, 8'd1, 8'd1, 1'b0, 17);
        run("gcd_zero", 8'd0,  8'd0,   8'd0,   8'd0, 8'd0, 1'b1, 1);
        run("inexact", 8'd12,  8'd18,  8'd5,   8'd2, 8'd3, exp_rem_err, 17);
        run("big",     8'd200, 8'd150, 8'd50,  8'd4, 8'd3, 1'b0, 17);

        // Backpressure: result must hold for five stalled cycles.
        out_ready = 1'b0;
        run("bp", 8'd12, 8'd18, 8'd6, 8'd2, 8'd3, 1'b0, 17);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_num", num_out, 2);
            chk("bp_hold_den", den_out, 3);
            chk("bp_hold_err", div_err, 0);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        run("bp_second", 8'd9, 8'd27, 8'd9, 8'd1, 8'd3, 1'b0, 17);

        // Reset three cycles into the denominator division.
        num_in   = 8'd12;
        den_in   = 8'd18;
        gcd_in   = 8'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(model(8'd12, 8'd18, 8'd6));
        repeat (11) @(posedge clk);
        #2;
        chk("mid_num_quotient", num_out, 2);
        chk("mid_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_num_out", num_out, 0);
        chk("mid_rst_den_out", den_out, 0);
        chk("mid_rst_div_err", div_err, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("post_rst", 8'd8, 8'd12, 8'd4, 8'd2, 8'd3, 1'b0, 17);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
